// File: rtl/dpram_initiator.sv
// -----------------------------------------------------------------------------
// dpram_initiator
//
// Turns a valid/ready command stream into accesses on a simple dual-port RAM.
// It returns read data through a valid/ready response channel.
//
// Writes are issued combinationally in the accept cycle and can run back-to-back
// at one per clock. A read is issued combinationally in its accept cycle. The
// RAM returns data one clock later. That data is captured in READ_WAIT and held
// in RSP_HOLD until the consumer takes it. New commands are stalled until then.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   cmd_valid/ready    command handshake
//   cmd_we             1 = write, 0 = read
//   cmd_addr           target address
//   cmd_wdata          write data
//   rsp_valid/ready    read response handshake
//   rsp_data           read result
//   ram_write_en       RAM write enable
//   ram_write_address  RAM write address
//   ram_data_in        RAM write data
//   ram_read_en        RAM read enable
//   ram_read_address   RAM read address
//   ram_data_out       RAM read data, valid one clock after ram_read_en
//   wr_count           accepted writes, saturating at 255
//   rd_count           completed read responses, saturating at 255
// -----------------------------------------------------------------------------
module dpram_initiator #(
   parameter int ADDR_WIDTH = 2,
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  ram_write_en,
   output logic [ADDR_WIDTH-1:0] ram_write_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_read_en,
   output logic [ADDR_WIDTH-1:0] ram_read_address,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic [7:0]            wr_count,
   output logic [7:0]            rd_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      RSP_HOLD  = 2'd2
   } state_t;

   state_t                state_r;
   logic                  rsp_valid_r;
   logic [DATA_WIDTH-1:0] rsp_data_r;
   logic [7:0]            wr_count_r;
   logic [7:0]            rd_count_r;

   logic                  accept_s;
   logic                  write_accept_s;
   logic                  read_accept_s;

   // Saturating increment: the counter holds at 255 and never wraps.
   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      if (value == 8'd255) begin
         return 8'd255;
      end else begin
         return value + 8'd1;
      end
   endfunction

   // Command acceptance and same-cycle RAM port drive.
   // Addresses and data follow the command bus freely; only the enables are qualified.
   always_comb begin
      cmd_ready         = 1'b0;
      accept_s          = 1'b0;
      write_accept_s    = 1'b0;
      read_accept_s     = 1'b0;
      ram_write_address = cmd_addr;
      ram_data_in       = cmd_wdata;
      ram_read_address  = cmd_addr;
      if ((state_r == IDLE) && !rst) begin
         cmd_ready = 1'b1;
      end else begin
         cmd_ready = 1'b0;
      end
      accept_s       = cmd_valid && cmd_ready;
      write_accept_s = accept_s && cmd_we;
      read_accept_s  = accept_s && !cmd_we;
      ram_write_en   = write_accept_s;
      ram_read_en    = read_accept_s;
   end

   // Read FSM, response register and saturating activity counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= {DATA_WIDTH{1'b0}};
         wr_count_r  <= 8'd0;
         rd_count_r  <= 8'd0;
      end else begin
         if (write_accept_s) begin
            wr_count_r <= sat_inc(wr_count_r);
         end
         case (state_r)
            IDLE: begin
               rsp_valid_r <= 1'b0;
               if (read_accept_s) begin
                  state_r <= READ_WAIT;
               end else begin
                  state_r <= IDLE;
               end
            end
            READ_WAIT: begin
               // The RAM output reflects the address issued in the accept cycle.
               rsp_data_r  <= ram_data_out;
               rsp_valid_r <= 1'b1;
               state_r     <= RSP_HOLD;
            end
            RSP_HOLD: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  rd_count_r  <= sat_inc(rd_count_r);
                  state_r     <= IDLE;
               end else begin
                  rsp_valid_r <= 1'b1;
                  state_r     <= RSP_HOLD;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign wr_count  = wr_count_r;
   assign rd_count  = rd_count_r;

endmodule

// File: tb/tb_dpram_initiator.sv
// -----------------------------------------------------------------------------
// tb_dpram_initiator
//
// Bench for dpram_initiator, backed by a behavioural dual-port RAM.
// Expected read data is pushed into a queue when a read is issued.
// A negedge monitor pops the queue and compares on every response handshake.
// Directed checks cover latency, stall, reset and counter saturation.
// -----------------------------------------------------------------------------
module tb_dpram_initiator;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_we;
   logic [1:0] cmd_addr;
   logic [3:0] cmd_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_data;
   logic       ram_write_en;
   logic [1:0] ram_write_address;
   logic [3:0] ram_data_in;
   logic       ram_read_en;
   logic [1:0] ram_read_address;
   logic [3:0] ram_data_out;
   logic [7:0] wr_count;
   logic [7:0] rd_count;

   int checks   = 0;
   int failures = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mem[4];

   always #5 clk = ~clk;

   dpram_initiator #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .ram_write_en(ram_write_en), .ram_write_address(ram_write_address),
      .ram_data_in(ram_data_in), .ram_read_en(ram_read_en),
      .ram_read_address(ram_read_address), .ram_data_out(ram_data_out),
      .wr_count(wr_count), .rd_count(rd_count)
   );

   // Behavioural RAM: synchronous write, registered read output.
   always @(posedge clk) begin
      if (ram_write_en) mem[ram_write_address] <= ram_data_in;
      if (ram_read_en)  ram_data_out <= mem[ram_read_address];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Response monitor: every handshake must match the oldest expected value.
   always @(negedge clk) begin
      chk("enable_exclusive", {31'd0, ram_write_en && ram_read_en}, 32'd0);
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
         end else begin
            chk("rsp_data", {28'd0, rsp_data}, {28'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!cmd_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_timeout", {31'd0, cmd_ready}, 32'd1);
   endtask

   task automatic do_write(input logic [1:0] addr, input logic [3:0] data);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = addr; cmd_wdata = data;
      #1;
      chk("wr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("wr_write_en", {31'd0, ram_write_en}, 32'd1);
      chk("wr_read_en", {31'd0, ram_read_en}, 32'd0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Issue a read with rsp_ready high; check t+1 / t+2 valid timing.
   task automatic do_read(input logic [1:0] addr, input logic [3:0] exp);
      exp_q.push_back(exp);
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = addr;
      #1;
      chk("rd_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rd_read_en", {31'd0, ram_read_en}, 32'd1);
      chk("rd_write_en", {31'd0, ram_write_en}, 32'd0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("rd_valid_t1", {31'd0, rsp_valid}, 32'd0);
      chk("rd_ready_t1", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rd_valid_t2", {31'd0, rsp_valid}, 32'd1);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      mem[0] = 4'hA; mem[1] = 4'hB; mem[2] = 4'hC; mem[3] = 4'hD;
      ram_data_out = 4'h0;
      rst = 1'b1; cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd0;
      cmd_wdata = 4'h0; rsp_ready = 1'b0;

      // Reset state, enables blocked while rst is high.
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_read_en", {31'd0, ram_read_en}, 32'd0);
      cmd_we = 1'b1; #1;
      chk("rst_write_en", {31'd0, ram_write_en}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", {28'd0, rsp_data}, 32'd0);
      chk("rst_wr_count", {24'd0, wr_count}, 32'd0);
      chk("rst_rd_count", {24'd0, rd_count}, 32'd0);
      cmd_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("idle_no_enable", {30'd0, ram_write_en, ram_read_en}, 32'd0);
      @(posedge clk); #1;

      // Preloaded read.
      do_read(2'd2, 4'hC);
      chk("rd_count_1", {24'd0, rd_count}, 32'd1);

      // Back-to-back writes, then read back.
      do_write(2'd0, 4'h5);
      do_write(2'd1, 4'h6);
      chk("wr_count_2", {24'd0, wr_count}, 32'd2);
      do_read(2'd1, 4'h6);
      chk("rd_count_2", {24'd0, rd_count}, 32'd2);

      // Response stall with rsp_ready low.
      exp_q.push_back(4'hD);
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd3;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
         chk("stall_data", {28'd0, rsp_data}, 32'hD);
         chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
         chk("stall_read_en", {31'd0, ram_read_en}, 32'd0);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release_idle", {31'd0, cmd_ready}, 32'd1);
      chk("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rd_count_3", {24'd0, rd_count}, 32'd3);

      // Read immediately after a write to the same address.
      do_write(2'd2, 4'h9);
      do_read(2'd2, 4'h9);
      chk("wr_count_3", {24'd0, wr_count}, 32'd3);
      chk("rd_count_4", {24'd0, rd_count}, 32'd4);

      // Reset during READ_WAIT discards the read.
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 2'd0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_rw_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_rw_read_en", {31'd0, ram_read_en}, 32'd0);
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rst_rw_ready_after", {31'd0, cmd_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("rst_rw_no_valid", {31'd0, rsp_valid}, 32'd0);
         @(posedge clk); #1;
      end
      chk("rst_rw_rd_count", {24'd0, rd_count}, 32'd0);
      chk("rst_rw_wr_count", {24'd0, wr_count}, 32'd0);

      // 260 back-to-back writes: the counter saturates at 255.
      cmd_valid = 1'b1; cmd_we = 1'b1;
      for (int i = 0; i < 260; i++) begin
         cmd_addr  = i[1:0];
         cmd_wdata = i[3:0];
         #1;
         chk("sat_cmd_ready", {31'd0, cmd_ready}, 32'd1);
         @(posedge clk); #1;
         if (i == 253) chk("wr_count_254", {24'd0, wr_count}, 32'd254);
         if (i == 254) chk("wr_count_255", {24'd0, wr_count}, 32'd255);
      end
      cmd_valid = 1'b0;
      chk("wr_count_sat", {24'd0, wr_count}, 32'd255);
      @(posedge clk); #1;
      chk("wr_count_hold", {24'd0, wr_count}, 32'd255);

      // The last write to addr3 carried data 3 (i = 259).
      do_read(2'd3, 4'h3);
      chk("rd_count_after_sat", {24'd0, rd_count}, 32'd1);

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dpram_initiator.md
DPRAM_INITIATOR -- requirements
Module: dpram_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 2, address width of the attached dual-port RAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, data width of the attached dual-port RAM.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-007 cmd_we  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDR_WIDTH  target address.
REQ-009 cmd_wdata  input  DATA_WIDTH  write data.
REQ-010 rsp_valid  output  1  read data available.
REQ-011 rsp_ready  input  1  consumer takes rsp_data when rsp_valid && rsp_ready.
REQ-012 rsp_data  output  DATA_WIDTH  read result.
REQ-013 ram_write_en  output  1  to RAM write_en.
REQ-014 ram_write_address  output  ADDR_WIDTH  to RAM write_address.
REQ-015 ram_data_in  output  DATA_WIDTH  to RAM data_in.
REQ-016 ram_read_en  output  1  to RAM read_en.
REQ-017 ram_read_address  output  ADDR_WIDTH  to RAM read_address.
REQ-018 ram_data_out  input  DATA_WIDTH  from RAM data_out; valid one clock after the read_en edge.
REQ-019 wr_count  output  8  accepted writes, saturating.
REQ-020 rd_count  output  8  completed read responses, saturating.

Function
REQ-021 SHALL implement FSM states IDLE, READ_WAIT, RSP_HOLD.
REQ-022 cmd_ready SHALL be 1 only in IDLE with rst low; 0 in READ_WAIT and RSP_HOLD.
REQ-023 Write accept in IDLE: ram_write_en=1, ram_write_address=cmd_addr, ram_data_in=cmd_wdata combinationally in the same cycle; state stays IDLE; back-to-back writes at one per cycle.
REQ-024 Read accept in IDLE: ram_read_en=1, ram_read_address=cmd_addr combinationally in the same cycle; next state READ_WAIT.
REQ-025 ram_write_en and ram_read_en SHALL never both be 1; both 0 whenever no command is accepted.
REQ-026 READ_WAIT: capture ram_data_out into rsp_data register at the edge; next state RSP_HOLD; unconditional (one cycle).
REQ-027 RSP_HOLD: rsp_valid=1, rsp_data stable; on rsp_valid && rsp_ready go to IDLE and increment rd_count.
REQ-028 Read latency: command accepted in cycle t -> rsp_valid first high in cycle t+2; minimum read throughput one per 3 cycles with rsp_ready held 1.
REQ-029 rsp_valid SHALL be 0 in IDLE and READ_WAIT; once high it stays high with unchanged rsp_data until the handshake or reset.
REQ-030 Read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-031 wr_count increments on each accepted write; both counters saturate at 255 (no wrap).
REQ-032 cmd_addr, cmd_wdata, cmd_we are don't-care when cmd_valid=0 or cmd_ready=0; RAM address/data outputs may follow them but enables stay 0.

Reset
REQ-033 rst high at a rising edge: state=IDLE, rsp_valid=0, rsp_data=0, wr_count=0, rd_count=0.
REQ-034 While rst is high: cmd_ready=0, ram_write_en=0, ram_read_en=0.
REQ-035 Reset in READ_WAIT or RSP_HOLD SHALL discard the pending read with no response and no rd_count increment.

Verification
REQ-036 RAM preloaded A,B,C,D; read addr 2 in cycle t, rsp_ready=1 -> rsp_valid=1, rsp_data=4'hC in cycle t+2; rd_count=1 after handshake.
REQ-037 Writes 5->addr0, 6->addr1 in consecutive cycles then read addr1 -> cmd_ready stays 1 for both writes, wr_count=2, rsp_data=4'h6.
REQ-038 Read addr3 with rsp_ready=0 for 5 cycles -> rsp_valid held 1, rsp_data=4'hD stable, cmd_ready=0; rsp_ready=1 -> IDLE next cycle.
REQ-039 Write 4'h9 to addr2 at cycle t, read addr2 at t+1 -> rsp_data=4'h9 at t+3.
REQ-040 Read addr0 accepted, rst asserted in READ_WAIT -> rsp_valid never asserts, rd_count=0, cmd_ready=1 first cycle after rst drops.
REQ-041 Issue 260 writes -> wr_count=255 and remains 255.
